// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, controller states, address width.
// Pure declarations; no logic, no latency.
// No flow control of its own; consumed by the controller and its timeout timer.
package cpu_pkg;

    localparam int ADDR_W = 13;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_PC_NEXT,
        ST_PC_SKIP,
        ST_HALT,
        ST_ERROR
    } state_t;

    // States that hold a memory request open
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/accum_ctrl_ack_timer.sv
// Memory-ack watchdog: counts unacked request cycles, flags expiry on the last allowed one.
// expired is combinational from the count and run; the count updates on the next edge.
// Never stalls anything; clr has priority over run.
module ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] cnt_q;

    // Count waiting cycles; restart on every new request phase
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    // Only a cycle that is still waiting can expire, so a late ack always wins
    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/accum_ctrl.sv
// Multi-cycle sequencer for the accumulator CPU: fetch, decode, memory access, PC update.
// Strobes are combinational from state and mem_ack; state advances one step per edge.
// Memory wait states hold the current state; an unacked request times out into ERROR.
module accum_ctrl
    import cpu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             load_ir,
    output logic             load_acc,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic             skip_q;
    logic [CNT_W-1:0] retired_q;
    logic             tmr_clr;
    logic             tmr_run;
    logic             tmr_expired;

    // Restart the watchdog whenever a fresh request phase begins
    assign tmr_clr = (state_d != state_q) && is_mem_state(state_d);
    assign tmr_run = mem_req && !mem_ack;

    ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .run    (tmr_run),
        .expired(tmr_expired)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)          state_d = ST_DECODE;
                else if (tmr_expired) state_d = ST_ERROR;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: state_d = ST_MEM_RD;
                    OP_STO:                         state_d = ST_MEM_WR;
                    default:                        state_d = ST_PC_NEXT;
                endcase
            end
            ST_MEM_RD, ST_MEM_WR: begin
                if (mem_ack)          state_d = ST_PC_NEXT;
                else if (tmr_expired) state_d = ST_ERROR;
            end
            ST_PC_NEXT: begin
                if (opcode == OP_HLT)                state_d = ST_HALT;
                else if (opcode == OP_SKZ && skip_q) state_d = ST_PC_SKIP;
                else                                 state_d = ST_FETCH;
            end
            ST_PC_SKIP: state_d = ST_FETCH;
            ST_HALT:    if (start) state_d = ST_FETCH;
            ST_ERROR:   state_d = ST_ERROR;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State, skip decision and retired-instruction count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            skip_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                skip_q <= (opcode == OP_SKZ) && zero;
            end
            if (state_q == ST_PC_NEXT) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Datapath strobes and memory handshake decoded from the current state
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        load_ir  = 1'b0;
        load_acc = 1'b0;
        inc_pc   = 1'b0;
        load_pc  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                load_ir = mem_ack;
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                load_acc = mem_ack;
            end
            ST_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
            end
            ST_PC_NEXT: begin
                if (opcode == OP_JMP) load_pc = 1'b1;
                else                  inc_pc  = 1'b1;
            end
            ST_PC_SKIP: inc_pc = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERROR);
    assign halted  = (state_q == ST_HALT);
    assign err     = (state_q == ST_ERROR);
    assign retired = retired_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl: cycle 0 is the start cycle, cycle 1 the first FETCH.
module tb_accum_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, zero, mem_ack;
    logic [2:0]  opcode;
    logic        mem_req, mem_we, addr_sel, load_ir, load_acc, inc_pc, load_pc;
    logic        busy, halted, err;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    logic [2:0]  prog [0:7];
    logic [63:0] m_req, m_we, m_ir, m_acc, m_inc, m_pc, m_halt, m_err, m_busy, m_fetch, m_rd;

    accum_ctrl #(.ACK_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .load_ir(load_ir), .load_acc(load_acc), .inc_pc(inc_pc), .load_pc(load_pc),
        .busy(busy), .halted(halted), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] outs();
        return {mem_req, mem_we, addr_sel, load_ir, load_acc, inc_pc, load_pc, busy, halted, err};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; zero = 1'b0; opcode = OP_HLT;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_prog(input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] c, input logic [2:0] d);
        prog[0] = a; prog[1] = b; prog[2] = c; prog[3] = d;
        for (int i = 4; i < 8; i++) prog[i] = OP_HLT;
    endtask

    // Drives start in cycle 0, plays the memory with per-phase ack delays,
    // feeds the next program opcode after each IR load, records per-cycle masks.
    task automatic run(input int ncyc, input int fetch_dly, input int rd_dly, input int wr_dly);
        int pi = 0;
        int waitc = 0;
        logic [2:0] nxt;
        {m_req, m_we, m_ir, m_acc, m_inc, m_pc} = '0;
        {m_halt, m_err, m_busy, m_fetch, m_rd} = '0;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0);
            if (!mem_req)       mem_ack = 1'b0;
            else if (!addr_sel) mem_ack = (waitc >= fetch_dly);
            else if (!mem_we)   mem_ack = (waitc >= rd_dly);
            else                mem_ack = (waitc >= wr_dly);
            #1;
            m_req[c]   = mem_req;   m_we[c]   = mem_we;   m_ir[c]   = load_ir;
            m_acc[c]   = load_acc;  m_inc[c]  = inc_pc;   m_pc[c]   = load_pc;
            m_halt[c]  = halted;    m_err[c]  = err;      m_busy[c] = busy;
            m_fetch[c] = mem_req && !addr_sel;
            m_rd[c]    = mem_req && addr_sel && !mem_we;
            if (mem_req && !mem_ack) waitc++;
            else                     waitc = 0;
            nxt = opcode;
            if (load_ir) begin
                nxt = prog[pi];
                if (pi < 7) pi++;
            end
            @(posedge clk);
            #1;
            opcode = nxt;
        end
        start   = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("reset_outs", outs(), 10'b0);
        chk("reset_retired", retired, 16'd0);

        // LDA, ADD, STO, HLT with zero-wait memory
        set_prog(OP_LDA, OP_ADD, OP_STO, OP_HLT);
        run(18, 0, 0, 0);
        chk("prog_load_acc", m_acc, 64'h88);
        chk("prog_mem_we", m_we, 64'h800);
        chk("prog_halted", m_halt, 64'h30000);
        chk("prog_load_ir", m_ir, 64'h2222);
        chk("prog_inc_pc", m_inc, 64'h9110);
        chk("prog_busy", m_busy, 64'hFFFE);
        chk("prog_retired", retired, 16'd4);

        // HALT resumes on start: FETCH in the next cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("resume_fetch", {mem_req, addr_sel, halted}, 3'b100);

        // JMP: load_pc in cycle 3, never inc_pc, FETCH again in cycle 4
        do_reset();
        set_prog(OP_JMP, OP_LDA, OP_HLT, OP_HLT);
        run(5, 0, 0, 0);
        chk("jmp_load_pc", m_pc, 64'h8);
        chk("jmp_inc_pc", m_inc, 64'h0);
        chk("jmp_fetch", m_fetch, 64'h12);

        // SKZ taken: two consecutive inc_pc pulses
        do_reset();
        zero = 1'b1;
        set_prog(OP_SKZ, OP_HLT, OP_HLT, OP_HLT);
        run(6, 0, 0, 0);
        chk("skz1_inc_pc", m_inc, 64'h18);
        chk("skz1_fetch", m_fetch, 64'h22);
        chk("skz1_retired", retired, 16'd1);

        // SKZ not taken: single pulse, FETCH in cycle 4
        do_reset();
        zero = 1'b0;
        set_prog(OP_SKZ, OP_HLT, OP_HLT, OP_HLT);
        run(5, 0, 0, 0);
        chk("skz0_inc_pc", m_inc, 64'h8);
        chk("skz0_fetch", m_fetch, 64'h12);

        // ADD with the read ack 5 cycles late
        do_reset();
        set_prog(OP_ADD, OP_HLT, OP_HLT, OP_HLT);
        run(11, 0, 5, 0);
        chk("slow_rd_req", m_rd, 64'h1F8);
        chk("slow_rd_load_acc", m_acc, 64'h100);
        chk("slow_rd_inc_pc", m_inc, 64'h200);
        chk("slow_rd_fetch", m_fetch, 64'h402);

        // Fetch ack on the last allowed cycle still wins over the timeout
        do_reset();
        set_prog(OP_JMP, OP_HLT, OP_HLT, OP_HLT);
        run(19, 15, 0, 0);
        chk("edge_ack_err", m_err, 64'h0);
        chk("edge_ack_load_pc", m_pc, 64'h40000);

        // Fetch never acked: 16 request cycles, then ERROR
        do_reset();
        set_prog(OP_JMP, OP_HLT, OP_HLT, OP_HLT);
        run(19, 1000, 0, 0);
        chk("timeout_req", m_req, 64'h1FFFE);
        chk("timeout_err", m_err, 64'h60000);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("error_ignores_start", outs(), 10'b0000000001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("error_rst_idle", outs(), 10'b0);

        // Reset in the middle of a stalled write
        do_reset();
        set_prog(OP_LDA, OP_STO, OP_HLT, OP_HLT);
        run(9, 0, 0, 1000);
        #1;
        chk("midwr_req", {mem_req, mem_we, addr_sel}, 3'b111);
        chk("midwr_retired", retired, 16'd1);
        rst = 1'b1;
        tick();
        #1;
        chk("midwr_rst_outs", outs(), 10'b0);
        chk("midwr_rst_retired", retired, 16'd0);
        rst = 1'b0;

        // Spurious ack in IDLE does nothing
        mem_ack = 1'b1;
        tick();
        tick();
        #1;
        chk("idle_spurious_ack", outs(), 10'b0);
        mem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Multi-cycle control sequencer for the 16-bit accumulator CPU datapath. It steps each instruction through fetch, decode, memory access and PC update. It issues the memory request handshake and generates the IR, accumulator and PC load strobes that the datapath registers consume. It sits between the instruction register/zero flag and the memory port, and it tracks retired instructions and memory-ack timeouts.

## Interface
- ACK_TIMEOUT, default 16: maximum cycles a memory request may wait for `mem_ack` before the controller faults.
- CNT_W, default 16: width of the retired-instruction counter.
- clk  in  1  system clock, all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse. Starts execution from IDLE, or resumes from HALT.
- opcode  in  3  `IR[15:13]` from the datapath. Valid from the DECODE cycle onward.
- zero  in  1  accumulator-equals-zero flag.
- mem_ack  in  1  memory completion; read data is valid in the same cycle.
- mem_req  out  1  memory request. Held high until it is acked.
- mem_we  out  1  write qualifier; meaningful only with `mem_req`.
- addr_sel  out  1  address source: 0 selects PC, 1 selects `IR[12:0]`.
- load_ir  out  1  IR load strobe.
- load_acc  out  1  accumulator load strobe; the ALU result is written on this edge.
- inc_pc  out  1  PC increment strobe.
- load_pc  out  1  PC load from `IR[12:0]`.
- busy  out  1  high in any state other than IDLE, HALT and ERROR.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.
- retired  out  CNT_W  count of retired instructions.

## Operation
- Opcodes:
  - HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
  - The ALU consumes `opcode` directly; this block does not re-encode it.
- States: IDLE, FETCH, DECODE, MEM_RD, MEM_WR, PC_NEXT, PC_SKIP, HALT, ERROR.
- Strobe outputs are combinational from the state and `mem_ack`. Every output not listed for a state is 0.
- IDLE:
  - `start` goes to FETCH; otherwise stay.
- FETCH:
  - Drive `mem_req`=1, `addr_sel`=0.
  - On `mem_ack`: `load_ir`=1, go to DECODE.
- DECODE:
  - No strobes. Register `zero` into `skip_r` (set only when the opcode is SKZ).
  - ADD, AND, XOR, LDA go to MEM_RD. STO goes to MEM_WR. HLT, SKZ, JMP go to PC_NEXT.
- MEM_RD:
  - Drive `mem_req`=1, `addr_sel`=1.
  - On `mem_ack`: `load_acc`=1, go to PC_NEXT.
- MEM_WR:
  - Drive `mem_req`=1, `mem_we`=1, `addr_sel`=1.
  - On `mem_ack`: go to PC_NEXT.
- PC_NEXT:
  - JMP asserts `load_pc`; every other opcode asserts `inc_pc`.
  - `retired` increments by 1, wrapping modulo 2^CNT_W.
  - Next state: HLT goes to HALT; SKZ with `skip_r`=1 goes to PC_SKIP; everything else goes to FETCH.
- PC_SKIP:
  - `inc_pc`=1, go to FETCH.
- HALT:
  - `halted`=1. `start` goes to FETCH; the PC already points past the HLT.
- ERROR:
  - `err`=1. The only exit is `rst`.
- Timeout:
  - A counter clears on every entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle that `mem_req` is high with no `mem_ack`.
  - When it reaches ACK_TIMEOUT-1 while `mem_ack`=0, the next state is ERROR and `mem_req` drops.
- `mem_ack` while `mem_req`=0 is ignored.
- `start` outside IDLE and HALT is ignored.

## Timing
- Reset:
  - state goes to IDLE; `retired`=0; timeout counter=0; `skip_r`=0.
  - All outputs are 0.
  - Reset applies in any state, including mid-request; `mem_req` drops the cycle after `rst` is sampled.
- Latency with zero-wait memory (ack in the same cycle as `mem_req`):
  - ADD, AND, XOR, LDA, STO: 4 cycles (FETCH, DECODE, MEM_*, PC_NEXT).
  - JMP, HLT, SKZ not taken: 3 cycles.
  - SKZ taken: 4 cycles.
- Wait states: each cycle that `mem_ack` is late adds exactly one cycle in the current memory state. The outputs stay stable throughout.
- Ack in the same cycle the timeout expires: the ack wins and the transition is normal.
- Back-to-back instructions: FETCH follows PC_NEXT or PC_SKIP with no idle cycle.
- `load_ir`, `load_acc`, `inc_pc` and `load_pc` are each high for exactly one cycle per event.

## Structure
- Shared package `cpu_pkg`: opcode localparams (HLT through JMP), the state enum encoding and the address width (13).
- Sub-module `ack_timer`: the timeout counter, with inputs clr and run and output expired. It is the only natural split.
- The FSM, strobe decode and retired counter stay in `accum_ctrl`.

## Test plan
- Reset then `start`, zero-wait memory, program LDA, ADD, STO, HLT:
  - `load_acc` pulses in cycles 3 and 7.
  - `mem_we` is high only in cycle 11.
  - `halted`=1 from cycle 16.
  - `retired`=4.
- JMP with `IR[12:0]`=0x0040: `load_pc`=1 in cycle 3, `inc_pc` never asserts, FETCH follows in cycle 4.
- SKZ with `zero`=1: `inc_pc` pulses in 2 consecutive cycles. With `zero`=0: a single pulse.
- ADD with `mem_ack` delayed 5 cycles in MEM_RD:
  - `mem_req` is held for 6 cycles.
  - `load_acc` fires once, in the ack cycle.
  - Instruction latency is 9 cycles.
- ACK_TIMEOUT=16 and `mem_ack` never asserts in FETCH:
  - ERROR is entered after 16 request cycles, with `err`=1 and `mem_req`=0.
  - `start` has no effect; `rst` returns to IDLE.
- `rst` asserted mid-MEM_WR with `mem_req` high:
  - Next cycle all outputs are 0 and `retired`=0.
  - A spurious `mem_ack` in IDLE is ignored.
